// File: rtl/mbm_pkg.sv
// rtl/mbm_pkg.sv - Shared state type, response codes and byte-lane helpers for mem_bus_master
package mbm_pkg;

  typedef enum logic [1:0] {IDLE, BUS, STAT, RESP} mbm_state_e;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  // Helpers take a fixed wide vector so any lane count can be zero-extended into them.
  localparam int MAX_SEL = 64;

  function automatic int lowest_set(input logic [MAX_SEL-1:0] sel);
    int idx;
    idx = 0;
    for (int i = MAX_SEL - 1; i >= 0; i--) begin
      if (sel[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int highest_set(input logic [MAX_SEL-1:0] sel);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_SEL; i++) begin
      if (sel[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mbm_lane_align.sv
// rtl/mbm_lane_align.sv - Byte-lane extraction/sign extension for reads and lane shift for writes
module mbm_lane_align
  import mbm_pkg::*;
#(
  parameter int WORD  = 16,
  parameter int SEL_W = WORD / 8
) (
  input  logic [WORD-1:0]  raw_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sext_i,
  input  logic [WORD-1:0]  wdata_i,
  output logic [WORD-1:0]  rdata_o,
  output logic [WORD-1:0]  wdata_o
);

  int              lo;
  int              hi;
  int              nbits;
  logic [WORD-1:0] shifted;
  logic [WORD-1:0] keep;
  logic [WORD-1:0] top;
  logic            sign;

  always_comb begin
    lo      = lowest_set(MAX_SEL'(sel_i));
    hi      = highest_set(MAX_SEL'(sel_i));
    nbits   = 8 * (hi - lo + 1);
    shifted = raw_i >> (8 * lo);
    wdata_o = wdata_i << (8 * lo);
    keep    = '0;
    top     = '0;
    for (int i = 0; i < WORD; i++) begin
      keep[i] = (i < nbits);
      top[i]  = (i == nbits - 1);
    end
    // Sign bit is the top bit of the selected field, found by mask to avoid a variable bit index.
    sign    = sext_i & (|(shifted & top));
    rdata_o = (shifted & keep) | (~keep & {WORD{sign}});
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - Single-outstanding Wishbone classic master with status-register bypass
// Define MBM_TIMEOUT_EN to build the bus watchdog that ends silent cycles after TIMEOUT clocks.
module mem_bus_master
  import mbm_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int ADDR_W  = 15,
  parameter int SEL_W   = WORD / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic              req_sext_i,
  input  logic              req_stat_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD-1:0]   req_wdata_i,
  input  logic [WORD-1:0]   psw_i,
  output logic              pswWr_o,
  output logic [WORD-1:0]   pswData_o,
  output logic              rsp_valid_o,
  output logic [WORD-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [WORD-1:0]   dat_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [WORD-1:0]   dat_o
);

  if (WORD % 8 != 0 || WORD < 16 || SEL_W != WORD / 8 || TIMEOUT < 1) begin : g_param_check
    $error("mem_bus_master: illegal parameter combination");
  end

  mbm_state_e        state_q, state_d;
  logic              we_q, sext_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD-1:0]   wdata_q;
  logic [WORD-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              expired;
  logic [WORD-1:0]   raw;
  logic [WORD-1:0]   aligned;
  logic [WORD-1:0]   wshift;

  assign accept = req_valid_i && (state_q == IDLE);
  assign raw    = (state_q == STAT) ? psw_i : dat_i;

  mbm_lane_align #(.WORD(WORD), .SEL_W(SEL_W)) u_align (
    .raw_i   (raw),
    .sel_i   (sel_q),
    .sext_i  (sext_q),
    .wdata_i (wdata_q),
    .rdata_o (aligned),
    .wdata_o (wshift)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= RSP_OK;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        sext_q  <= req_sext_i;
        sel_q   <= req_sel_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

`ifdef MBM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside BUS, so every bus cycle starts counting from a clean slate.
  assign cnt_d   = (state_q == BUS) ? cnt_q + 1'b1 : '0;
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rdata_d = '0;
          err_d   = RSP_OK;
          if (req_stat_i) begin
            state_d = STAT;
          end else if (req_sel_i == '0) begin
            state_d = RESP;
            err_d   = RSP_ERR;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (err_i) begin
          state_d = RESP;
          err_d   = RSP_ERR;
        end else if (ack_i) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : aligned;
        end else if (expired) begin
          state_d = RESP;
          err_d   = RSP_ERR;
        end
      end
      STAT: begin
        if (!we_q) rdata_d = aligned;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign cyc_o       = (state_q == BUS);
  assign stb_o       = cyc_o;
  assign we_o        = cyc_o & we_q;
  assign sel_o       = cyc_o ? sel_q : '0;
  assign adr_o       = addr_q;
  assign dat_o       = wshift;
  assign pswWr_o     = (state_q == STAT) & we_q;
  assign pswData_o   = wdata_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;

endmodule
